// File: rtl/rgb_sink.sv
// Double-buffered RGB pixel sink: two 64-entry banks are filled from the input
// stream and drained in close order through a registered valid/ready output.
module rgb_sink (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] size_x,
  input  logic [31:0] size_y,
  input  logic [31:0] R_I,
  input  logic [31:0] G_I,
  input  logic [31:0] B_I,
  input  logic        en_write,
  output logic        in_ready,
  output logic [31:0] R_O,
  output logic [31:0] G_O,
  output logic [31:0] B_O,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        finish_64,
  output logic        finish
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_total, r_count;
  logic [5:0]      r_wptr, r_rptr;
  logic            r_wbank, r_rbank, r_lastld;
  logic [1:0]      r_full, w_full_nxt;
  logic [1:0][6:0] r_len;
  logic [95:0]     r_mem [128];

  logic [31:0] w_total;
  logic        w_start_ok, w_wr, w_close, w_adv, w_free, w_load, w_rlast;
  logic [6:0]  w_rlen;

  assign w_total    = size_x * size_y;
  assign w_start_ok = start && (r_state != RUN);
  assign in_ready   = (r_state == RUN) && !r_full[r_wbank] && (r_count < r_total);
  assign w_wr       = en_write && in_ready;
  assign w_close    = w_wr && ((r_wptr == 6'd63) || (r_count + 32'd1 == r_total));
  assign finish     = (r_state == DONE);

  // Output register accepts a new entry whenever it is empty or being consumed.
  // r_lastld blocks further loads once a bank's last entry sits in the register.
  assign w_adv   = !out_valid || out_ready;
  assign w_free  = out_valid && out_ready && out_last;
  assign w_load  = w_adv && r_full[r_rbank] && !r_lastld;
  assign w_rlen  = r_len[r_rbank];
  assign w_rlast = ({1'b0, r_rptr} == (w_rlen - 7'd1));

  always_comb begin
    w_full_nxt = r_full;
    if (w_close) w_full_nxt[r_wbank] = 1'b1;
    if (w_free)  w_full_nxt[r_rbank] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = (w_total == '0) ? DONE : RUN;
      RUN:        if ((r_count == r_total) && (r_full == '0) && !out_valid) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[{r_wbank, r_wptr}] <= {R_I, G_I, B_I};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total   <= '0;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_wbank   <= 1'b0;
      r_rbank   <= 1'b0;
      r_lastld  <= 1'b0;
      r_full    <= '0;
      r_len     <= '0;
      finish_64 <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      R_O       <= '0;
      G_O       <= '0;
      B_O       <= '0;
    end else if (w_start_ok) begin
      r_total   <= w_total;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_wbank   <= 1'b0;
      r_rbank   <= 1'b0;
      r_lastld  <= 1'b0;
      r_full    <= '0;
      r_len     <= '0;
      finish_64 <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      finish_64 <= w_close;
      r_full    <= w_full_nxt;
      if (w_wr) begin
        r_count <= r_count + 32'd1;
        r_wptr  <= r_wptr + 6'd1;
      end
      if (w_close) begin
        r_len[r_wbank] <= {1'b0, r_wptr} + 7'd1;
        r_wptr         <= '0;
        r_wbank        <= ~r_wbank;
      end
      if (w_free) begin
        r_rbank  <= ~r_rbank;
        r_rptr   <= '0;
        r_lastld <= 1'b0;
      end
      if (w_load) begin
        {R_O, G_O, B_O} <= r_mem[{r_rbank, r_rptr}];
        out_valid       <= 1'b1;
        out_last        <= w_rlast;
        r_lastld        <= w_rlast;
        r_rptr          <= w_rlast ? 6'd0 : r_rptr + 6'd1;
      end else if (w_adv) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_sink.sv
// Directed bench for rgb_sink: accepted pixels are pushed to a scoreboard queue
// and popped against each output beat; stalled beats must hold their value.
module tb_rgb_sink;

  logic        clk = 1'b0;
  logic        rst_n, start, en_write, out_ready;
  logic [31:0] size_x, size_y, R_I, G_I, B_I;
  logic        in_ready, out_valid, out_last, finish_64, finish;
  logic [31:0] R_O, G_O, B_O;

  rgb_sink dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size_x(size_x), .size_y(size_y),
    .R_I(R_I), .G_I(G_I), .B_I(B_I), .en_write(en_write), .in_ready(in_ready),
    .R_O(R_O), .G_O(G_O), .B_O(B_O), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .finish_64(finish_64), .finish(finish)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cur_idx, cur_base, cur_total, beats, f64;
  logic [96:0] sb [$];
  logic        held_valid = 1'b0;
  logic [96:0] held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [96:0] pix(input int idx, input int base, input int total);
    logic [31:0] r;
    logic        last;
    r    = 32'(base + idx);
    last = ((idx % 64) == 63) || (idx == total - 1);
    return {r, r + 32'd100, r + 32'd200, last};
  endfunction

  // One clock: sample at negedge, then advance to just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (held_valid && out_valid) chk("stall_hold", {R_O, G_O, B_O, out_last}, held);
    held_valid = out_valid && !out_ready;
    held       = {R_O, G_O, B_O, out_last};
    if (finish_64) f64++;
    if (en_write && in_ready) begin
      sb.push_back(pix(cur_idx, cur_base, cur_total));
      cur_idx++;
    end
    if (out_valid && out_ready) begin
      beats++;
      if (sb.size() == 0) chk("unexpected_beat", {R_O, G_O, B_O, out_last}, '0);
      else                chk("beat", {R_O, G_O, B_O, out_last}, sb.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sx, input int sy, input int base);
    cur_idx   = 0;
    cur_base  = base;
    cur_total = sx * sy;
    beats     = 0;
    f64       = 0;
    size_x    = 32'(sx);
    size_y    = 32'(sy);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic send(input int n, input bit rnd_ready);
    int target;
    int guard;
    target = cur_idx + n;
    guard  = 0;
    while (cur_idx < target && guard < 5000) begin
      R_I = 32'(cur_base + cur_idx);
      G_I = R_I + 32'd100;
      B_I = R_I + 32'd200;
      en_write = 1'b1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    en_write = 1'b0;
    if (guard >= 5000) chk("send_timeout", 128'(cur_idx), 128'(target));
  endtask

  task automatic drain(input bit rnd_ready);
    int guard;
    guard = 0;
    while (!finish && guard < 5000) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      guard++;
    end
    out_ready = 1'b1;
    chk("finish", 128'(finish), 128'(1));
    chk("sb_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; en_write = 1'b0; out_ready = 1'b1;
    size_x = '0; size_y = '0; R_I = '0; G_I = '0; B_I = '0;
    cur_idx = 0; cur_base = 0; cur_total = 0; beats = 0; f64 = 0;
    #1;
    chk("rst_ctrl", {in_ready, out_valid, out_last, finish_64, finish}, '0);
    chk("rst_data", {R_O, G_O, B_O}, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Stream 8x8
    do_start(8, 8, 0);
    send(64, 1'b0);
    drain(1'b0);
    chk("stream_beats", 128'(beats), 128'(64));
    chk("stream_f64", 128'(f64), 128'(1));

    // Ping-pong with full backpressure, 16x8
    out_ready = 1'b0;
    do_start(16, 8, 2000);
    send(128, 1'b0);
    chk("pp_accepts", 128'(cur_idx), 128'(128));
    R_I = 32'hDEAD; G_I = 32'hDEAD; B_I = 32'hDEAD; en_write = 1'b1;
    repeat (3) begin
      step();
      chk("pp_in_ready", 128'(in_ready), 128'(0));
    end
    en_write = 1'b0;
    chk("pp_held_head", {out_valid, R_O, G_O, B_O, out_last},
        {1'b1, pix(0, 2000, 128)});
    drain(1'b1);
    chk("pp_beats", 128'(beats), 128'(128));
    chk("pp_f64", 128'(f64), 128'(2));

    // Partial last bank, 10x10
    do_start(10, 10, 5000);
    send(100, 1'b1);
    drain(1'b1);
    chk("part_beats", 128'(beats), 128'(100));
    chk("part_f64", 128'(f64), 128'(2));

    // Zero-sized frame
    do_start(0, 5, 0);
    chk("zero_finish", 128'(finish), 128'(1));
    en_write = 1'b1;
    repeat (4) begin
      step();
      chk("zero_in_ready", 128'(in_ready), 128'(0));
    end
    en_write = 1'b0;
    chk("zero_beats", 128'(beats), 128'(0));

    // Restart from DONE; start during RUN ignored
    do_start(8, 8, 1000);
    chk("restart_finish_low", 128'(finish), 128'(0));
    send(20, 1'b0);
    size_x = 32'd1; size_y = 32'd1; start = 1'b1;
    step();
    start = 1'b0;
    send(44, 1'b0);
    drain(1'b0);
    chk("restart_beats", 128'(beats), 128'(64));
    chk("restart_f64", 128'(f64), 128'(1));

    // Mid-frame reset discards buffered pixels
    out_ready = 1'b0;
    do_start(8, 8, 3000);
    send(40, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {in_ready, out_valid, out_last, finish_64, finish}, '0);
    chk("mid_rst_data", {R_O, G_O, B_O}, '0);
    sb.delete();
    held_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    do_start(8, 8, 7000);
    send(64, 1'b1);
    drain(1'b1);
    chk("post_rst_beats", 128'(beats), 128'(64));
    chk("post_rst_f64", 128'(f64), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
